memory_rw: RTL and testbench

Parametrised single-port word memory with a valid/ready request channel, a registered response channel with backpressure, per-lane write masking, and an optional post-reset clear sequencer. It is the general-purpose storage block for FPGA test designs, replacing fixed 8-bit, 256-entry arrays. The array depth is exactly 2**ADDRESS_BITS entries.

---
 rtl/memory_rw.sv | 125 ++++++++++++
 tb/tb_memory_rw.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_rw.sv
// memory_rw: single-port word memory with valid/ready request and registered, backpressured response.
// Define MEMORY_CLEAR_EN to compile in the post-reset clear sequencer (CLEAR/RUN FSM, busy output).
module memory_rw #(
    parameter int ADDRESS_BITS = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int LANE_WIDTH   = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_write,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   req_mask,
    input  logic [ADDRESS_BITS-1:0]            req_address,
    input  logic [DATA_WIDTH-1:0]              req_data,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [DATA_WIDTH-1:0]              resp_data,
    output logic                               busy
);

    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH = 1 << ADDRESS_BITS;

    // Handshake: a request transfers on a posedge where req_valid && req_ready;
    // a response transfers on a posedge where resp_valid && resp_ready.
    // resp_valid/resp_data never change while resp_valid && !resp_ready.

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   merged;
    logic                    run;
    logic                    accept;
    logic                    mem_we;
    logic [ADDRESS_BITS-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    assign rd_word = mem[req_address];

    always_comb begin
        merged = rd_word;
        for (int i = 0; i < LANES; i++) begin
            if (req_mask[i]) begin
                merged[i*LANE_WIDTH +: LANE_WIDTH] = req_data[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    assign req_ready = run && !reset && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;

`ifdef MEMORY_CLEAR_EN
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDRESS_BITS-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Single pass: leave CLEAR right after the last address is zeroed.
    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_cnt == '1) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        run       = (state == ST_RUN);
        busy      = (state == ST_CLEAR);
        mem_we    = 1'b0;
        mem_waddr = req_address;
        mem_wdata = merged;
        if (state == ST_CLEAR) begin
            mem_we    = !reset;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
        end else if (accept && req_write) begin
            mem_we = 1'b1;
        end
    end
`else
    always_comb begin
        run       = 1'b1;
        busy      = 1'b0;
        mem_we    = accept && req_write;
        mem_waddr = req_address;
        mem_wdata = merged;
    end
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Write-first: a write response carries the merged word just stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_data  <= req_write ? merged : rd_word;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_rw.sv
// Self-checking bench for memory_rw (ADDRESS_BITS=8, DATA_WIDTH=32, LANE_WIDTH=8).
// Works with or without MEMORY_CLEAR_EN defined.
module tb_memory_rw;

    localparam int AB    = 8;
    localparam int DW    = 32;
    localparam int LW    = 8;
    localparam int LN    = DW / LW;
    localparam int DEPTH = 1 << AB;
`ifdef MEMORY_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [LN-1:0] req_mask;
    logic [AB-1:0] req_address;
    logic [DW-1:0] req_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          busy;

    memory_rw #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW), .LANE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_mask(req_mask), .req_address(req_address), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    logic [DW-1:0] mmem   [DEPTH];
    bit            mknown [DEPTH];
    logic [DW-1:0] exp_q [$];
    bit            care_q[$];
    int            clear_left = 0;
    bit            live = 1'b0;

    initial begin
        for (int i = 0; i < DEPTH; i++) mknown[i] = 1'b0;
    end

    // Each negedge checks the outputs, then models the coming posedge.
    always @(negedge clk) begin
        logic [DW-1:0] w;
        bit            c;
        bit            acc;
        if (live) begin
            check("resp_valid", DW'(resp_valid), DW'(exp_q.size() != 0));
            if (exp_q.size() != 0 && care_q[0]) check("resp_data", resp_data, exp_q[0]);
            check("busy", DW'(busy), DW'(clear_left > 0));
            check("req_ready", DW'(req_ready),
                  DW'(!reset && clear_left == 0 && (exp_q.size() == 0 || resp_ready)));
        end
        if (reset) begin
            live = 1'b1;
            exp_q.delete();
            care_q.delete();
            clear_left = CLR ? DEPTH : 0;
        end else if (live) begin
            if (clear_left > 0) begin
                clear_left--;
                if (clear_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mmem[i]   = '0;
                        mknown[i] = 1'b1;
                    end
                end
            end else begin
                acc = req_valid && (exp_q.size() == 0 || resp_ready);
                if (exp_q.size() != 0 && resp_ready) begin
                    void'(exp_q.pop_front());
                    void'(care_q.pop_front());
                end
                if (acc) begin
                    w = mmem[req_address];
                    c = mknown[req_address];
                    if (req_write) begin
                        for (int i = 0; i < LN; i++)
                            if (req_mask[i]) w[i*LW +: LW] = req_data[i*LW +: LW];
                        if (req_mask == '1) c = 1'b1;
                        mmem[req_address]   = w;
                        mknown[req_address] = c;
                    end
                    exp_q.push_back(w);
                    care_q.push_back(c);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_req(input bit w, input logic [LN-1:0] m, input logic [AB-1:0] a,
                          input logic [DW-1:0] d);
        bit ok = 1'b0;
        req_valid = 1'b1; req_write = w; req_mask = m; req_address = a; req_data = d;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout actual=no_accept required=accept addr=%0d", a);
        end
        req_valid = 1'b0;
    endtask

    // Response must be visible in the cycle right after acceptance.
    task automatic expect_resp(input string name, input logic [DW-1:0] v);
        @(negedge clk);
        check({name, "_valid"}, DW'(resp_valid), DW'(1));
        check(name, resp_data, v);
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int n;
    int t0;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_mask = '0;
        req_address = '0; req_data = '0; resp_ready = 1'b1;
        do_reset();

        if (CLR) begin
            count_busy(n);
            check("clear_len", DW'(n), DW'(256));
            do_req(1'b0, '0, 8'd0, '0);   expect_resp("clr_rd0", 32'h0);
            do_req(1'b0, '0, 8'd77, '0);  expect_resp("clr_rd77", 32'h0);
            do_req(1'b0, '0, 8'd255, '0); expect_resp("clr_rd255", 32'h0);
        end else begin
            @(negedge clk);
            check("first_busy", DW'(busy), DW'(0));
            check("first_ready", DW'(req_ready), DW'(1));
            @(posedge clk); #1;
            do_req(1'b1, 4'hF, 8'd7, 32'hCAFE_F00D); expect_resp("wr7", 32'hCAFE_F00D);
            do_req(1'b0, '0, 8'd7, '0);              expect_resp("rd7", 32'hCAFE_F00D);
        end

        // masked writes, write-first responses
        do_req(1'b1, 4'b1111, 8'd5, 32'h1122_3344); expect_resp("mw_full", 32'h1122_3344);
        do_req(1'b1, 4'b0101, 8'd5, 32'hAABB_CCDD); expect_resp("mw_0101", 32'h11BB_33DD);
        do_req(1'b0, '0, 8'd5, '0);                 expect_resp("mw_rd", 32'h11BB_33DD);
        do_req(1'b1, 4'b0000, 8'd5, 32'hFFFF_FFFF); expect_resp("mw_none", 32'h11BB_33DD);
        do_req(1'b0, '0, 8'd5, '0);                 expect_resp("mw_rd2", 32'h11BB_33DD);

        // backpressure
        do_req(1'b1, 4'hF, 8'd3, 32'h42); expect_resp("bp_wr", 32'h42);
        resp_ready = 1'b0;
        do_req(1'b0, '0, 8'd3, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_ready", DW'(req_ready), DW'(0));
            check("bp_data", resp_data, 32'h42);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_consume_ready", DW'(req_ready), DW'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_after_valid", DW'(resp_valid), DW'(0));
        check("bp_after_ready", DW'(req_ready), DW'(1));
        check("bp_hold_data", resp_data, 32'h42);
        @(posedge clk); #1;

        // streaming writes then reads, one per cycle
        t0 = cyc;
        for (int i = 0; i < 16; i++) do_req(1'b1, 4'hF, AB'(i), DW'(i * 3));
        check("stream_wr_cycles", DW'(cyc - t0), DW'(16));
        t0 = cyc;
        for (int i = 0; i < 16; i++) do_req(1'b0, '0, AB'(i), '0);
        check("stream_rd_cycles", DW'(cyc - t0), DW'(16));
        expect_resp("stream_last", 32'd45);
        tick();

        if (CLR) begin
            do_reset();
            repeat (100) tick();
            check("mid_busy", DW'(busy), DW'(1));
            do_reset();
            count_busy(n);
            check("reclear_len", DW'(n), DW'(256));
            do_req(1'b0, '0, 8'd5, '0); expect_resp("reclear_rd5", 32'h0);
        end else begin
            // reset drops a pending response
            resp_ready = 1'b0;
            do_req(1'b0, '0, 8'd7, '0);
            do_reset();
            @(negedge clk);
            check("rst_drop_valid", DW'(resp_valid), DW'(0));
            check("rst_drop_data", resp_data, 32'h0);
            @(posedge clk); #1;
            resp_ready = 1'b1;
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
